// File: rtl/regfile_write_buffer.sv
// Writeback buffer in front of a single register file write port: queues
// writebacks while the port is held, drains in order, and forwards pending data.
module regfile_write_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     wb_valid,
  input  logic [4:0]               wb_sel,
  input  logic [31:0]              wb_dat,
  output logic                     wb_ready,
  input  logic                     rf_hold,
  output logic                     WEN,
  output logic [4:0]               wsel,
  output logic [31:0]              wdat,
  input  logic [4:0]               rsel1,
  input  logic [4:0]               rsel2,
  input  logic [31:0]              rf_rdat1,
  input  logic [31:0]              rf_rdat2,
  output logic [31:0]              rdat1,
  output logic [31:0]              rdat2,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int SEL_W  = 5;
  localparam int DATA_W = 32;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [SEL_W-1:0]  sel_q [DEPTH];
  logic [DATA_W-1:0] dat_q [DEPTH];
  logic [PTR_W-1:0]  head_q, tail_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push, enq, pop, occupied;

  assign occupied = (count_q != '0);
  assign wb_ready = (count_q < CNT_FULL);
  assign push     = wb_valid && wb_ready;
  // Writes to r0 complete the handshake but are never stored.
  assign enq      = push && (wb_sel != '0);
  assign pop      = occupied && !rf_hold;

  assign WEN   = pop;
  assign wsel  = occupied ? sel_q[head_q] : '0;
  assign wdat  = occupied ? dat_q[head_q] : '0;
  assign count = count_q;

  always_comb begin
    count_d = count_q;
    case ({enq, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        sel_q[i] <= '0;
        dat_q[i] <= '0;
      end
    end else begin
      if (enq) begin
        sel_q[tail_q] <= wb_sel;
        dat_q[tail_q] <= wb_dat;
        tail_q        <= tail_q + PTR_ONE;
      end
      if (pop) head_q <= head_q + PTR_ONE;
      count_q <= count_d;
    end
  end

  // Walk oldest to youngest so the last match wins; only registered state is
  // consulted, so an in-flight push is never forwarded.
  always_comb begin
    logic [PTR_W-1:0] idx;
    rdat1 = rf_rdat1;
    rdat2 = rf_rdat2;
    idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PTR_W'(i);
      if (CNT_W'(i) < count_q) begin
        if (sel_q[idx] == rsel1) rdat1 = dat_q[idx];
        if (sel_q[idx] == rsel2) rdat2 = dat_q[idx];
      end
    end
    if (rsel1 == '0) rdat1 = '0;
    if (rsel2 == '0) rdat2 = '0;
  end

endmodule

// File: tb/tb_regfile_write_buffer.sv
// Directed bench for regfile_write_buffer (DEPTH=4): drain latency, hold/full,
// forwarding, r0 handling, continuous wrap-around streaming and mid-run reset.
module tb_regfile_write_buffer;

  logic        CLK, nRST;
  logic        wb_valid;
  logic [4:0]  wb_sel;
  logic [31:0] wb_dat;
  logic        wb_ready;
  logic        rf_hold;
  logic        WEN;
  logic [4:0]  wsel;
  logic [31:0] wdat;
  logic [4:0]  rsel1, rsel2;
  logic [31:0] rf_rdat1, rf_rdat2;
  logic [31:0] rdat1, rdat2;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;

  regfile_write_buffer #(.DEPTH(4)) dut (
    .CLK(CLK), .nRST(nRST),
    .wb_valid(wb_valid), .wb_sel(wb_sel), .wb_dat(wb_dat), .wb_ready(wb_ready),
    .rf_hold(rf_hold), .WEN(WEN), .wsel(wsel), .wdat(wdat),
    .rsel1(rsel1), .rsel2(rsel2), .rf_rdat1(rf_rdat1), .rf_rdat2(rf_rdat2),
    .rdat1(rdat1), .rdat2(rdat2), .count(count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  logic [36:0] mq[$];
  int mcount, nxt, got;
  logic mpush, mpop;

  initial begin
    nRST = 1'b0; wb_valid = 1'b0; wb_sel = '0; wb_dat = '0; rf_hold = 1'b0;
    rsel1 = 5'd3; rsel2 = 5'd0; rf_rdat1 = 32'h1234; rf_rdat2 = 32'h5678;
    #2;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_wen", 32'(WEN), 32'd0);
    chk("rst_wsel", 32'(wsel), 32'd0);
    chk("rst_wdat", wdat, 32'd0);
    chk("rst_ready", 32'(wb_ready), 32'd1);
    chk("rst_rdat1", rdat1, 32'h1234);
    chk("rst_rdat2_r0", rdat2, 32'd0);
    cyc();
    nRST = 1'b1;
    cyc();

    // single entry drain latency
    wb_valid = 1'b1; wb_sel = 5'd5; wb_dat = 32'hDEADBEEF;
    #1;
    chk("lat_ready", 32'(wb_ready), 32'd1);
    chk("lat_nofwd_same_cycle", 32'(WEN), 32'd0);
    cyc();
    wb_valid = 1'b0;
    #1;
    chk("lat_wen", 32'(WEN), 32'd1);
    chk("lat_wsel", 32'(wsel), 32'd5);
    chk("lat_wdat", wdat, 32'hDEADBEEF);
    chk("lat_count1", 32'(count), 32'd1);
    cyc();
    chk("lat_count0", 32'(count), 32'd0);
    chk("lat_wen0", 32'(WEN), 32'd0);
    chk("lat_wsel0", 32'(wsel), 32'd0);

    // fill under hold, stalled fifth push, then ordered drain
    rf_hold = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      wb_valid = 1'b1; wb_sel = 5'(k); wb_dat = 32'(k * 'h11);
      cyc();
    end
    wb_sel = 5'd9; wb_dat = 32'h99;
    #1;
    chk("full_count", 32'(count), 32'd4);
    chk("full_ready", 32'(wb_ready), 32'd0);
    chk("full_wen", 32'(WEN), 32'd0);
    chk("full_head_wsel", 32'(wsel), 32'd1);
    cyc();
    wb_valid = 1'b0;
    #1;
    chk("stall_count", 32'(count), 32'd4);
    rf_hold = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      #1;
      chk("drain_wen", 32'(WEN), 32'd1);
      chk("drain_wsel", 32'(wsel), 32'(k));
      chk("drain_wdat", wdat, 32'(k * 'h11));
      cyc();
    end
    chk("drain_count0", 32'(count), 32'd0);
    chk("drain_wen0", 32'(WEN), 32'd0);

    // forwarding: youngest wins, same-cycle push not visible
    rf_hold = 1'b1;
    rsel1 = 5'd7; rf_rdat1 = 32'h77;
    wb_valid = 1'b1; wb_sel = 5'd7; wb_dat = 32'hA;
    #1;
    chk("fwd_none_yet", rdat1, 32'h77);
    cyc();
    wb_sel = 5'd7; wb_dat = 32'hB;
    #1;
    chk("fwd_older_only", rdat1, 32'hA);
    cyc();
    wb_valid = 1'b0; rf_rdat1 = 32'h0; rsel2 = 5'd8; rf_rdat2 = 32'h55;
    #1;
    chk("fwd_youngest", rdat1, 32'hB);
    chk("fwd_miss_rdat2", rdat2, 32'h55);
    chk("fwd_count", 32'(count), 32'd2);
    rsel2 = 5'd7;
    #1;
    chk("fwd_rdat2_hit", rdat2, 32'hB);
    rf_hold = 1'b0;
    #1;
    chk("fwd_drain1_wdat", wdat, 32'hA);
    chk("fwd_drain1_rdat1", rdat1, 32'hB);
    cyc();
    chk("fwd_drain2_wdat", wdat, 32'hB);
    chk("fwd_head_rdat1", rdat1, 32'hB);
    cyc();
    rf_rdat1 = 32'h77;
    #1;
    chk("fwd_empty_rdat1", rdat1, 32'h77);

    // register 0 push: handshake only
    wb_valid = 1'b1; wb_sel = 5'd0; wb_dat = 32'hFFFFFFFF;
    #1;
    chk("r0_ready", 32'(wb_ready), 32'd1);
    cyc();
    wb_valid = 1'b0; rsel1 = 5'd0; rf_rdat1 = 32'h99;
    #1;
    chk("r0_count", 32'(count), 32'd0);
    chk("r0_wen", 32'(WEN), 32'd0);
    chk("r0_rdat1", rdat1, 32'd0);

    // continuous streaming from full, 12 requests, pointer wrap
    mq.delete();
    rf_hold = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wb_valid = 1'b1; wb_sel = 5'(k + 1); wb_dat = 32'h100 + 32'(k);
      mq.push_back({wb_sel, wb_dat});
      cyc();
    end
    wb_valid = 1'b0;
    #1;
    chk("stream_full", 32'(count), 32'd4);
    rf_hold = 1'b0;
    mcount = 4; nxt = 4; got = 0;
    for (int c = 0; c < 60 && got < 12; c++) begin
      wb_valid = (nxt < 12); wb_sel = 5'(nxt + 1); wb_dat = 32'h100 + 32'(nxt);
      #1;
      chk("stream_count", 32'(count), 32'(mcount));
      chk("stream_ready", 32'(wb_ready), 32'(mcount < 4));
      chk("stream_wen", 32'(WEN), 32'(mcount != 0));
      mpop  = (mcount != 0);
      mpush = wb_valid && (mcount < 4);
      if (mpop) begin
        chk("stream_wsel", 32'(wsel), 32'(mq[0][36:32]));
        chk("stream_wdat", wdat, mq[0][31:0]);
        void'(mq.pop_front());
        got++;
      end
      if (mpush) begin
        mq.push_back({wb_sel, wb_dat});
        nxt++;
      end
      mcount = mcount + int'(mpush) - int'(mpop);
      cyc();
    end
    wb_valid = 1'b0;
    #1;
    chk("stream_all_written", 32'(got), 32'd12);
    chk("stream_end_count", 32'(count), 32'd0);

    // reset pulsed between edges with three pending entries
    rf_hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wb_valid = 1'b1; wb_sel = 5'(k + 3); wb_dat = 32'hC0 + 32'(k);
      cyc();
    end
    wb_valid = 1'b0;
    #1;
    chk("mrst_pending", 32'(count), 32'd3);
    #1;
    nRST = 1'b0; rf_hold = 1'b0;
    #1;
    chk("mrst_count", 32'(count), 32'd0);
    chk("mrst_wen", 32'(WEN), 32'd0);
    chk("mrst_wsel", 32'(wsel), 32'd0);
    chk("mrst_ready", 32'(wb_ready), 32'd1);
    #1;
    nRST = 1'b1;
    rsel1 = 5'd3; rf_rdat1 = 32'hCAFE;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("mrst_no_stale_wen", 32'(WEN), 32'd0);
    end
    chk("mrst_rdat1_pass", rdat1, 32'hCAFE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_write_buffer.md
REGFILE_WRITE_BUFFER -- requirements
Module: regfile_write_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the number of buffered writebacks (power of two, at least 2).
REQ-002 CLK  input  1  system clock; all state SHALL update on the rising edge.
REQ-003 nRST  input  1  reset; SHALL be asynchronous and active-low.
REQ-004 wb_valid  input  1  writeback request from the pipeline.
REQ-005 wb_sel  input  5  destination register of the request.
REQ-006 wb_dat  input  32  data to be written.
REQ-007 wb_ready  output  1  buffer can accept a request this cycle.
REQ-008 rf_hold  input  1  register file write port unavailable this cycle.
REQ-009 WEN  output  1  write enable to the register file write port.
REQ-010 wsel  output  5  register file write select.
REQ-011 wdat  output  32  register file write data.
REQ-012 rsel1, rsel2  input  5 each  decode-stage read selects, also driven to the register file.
REQ-013 rf_rdat1, rf_rdat2  input  32 each  raw read data returned by the register file.
REQ-014 rdat1, rdat2  output  32 each  read data after forwarding from the buffer.
REQ-015 count  output  log2(DEPTH)+1  number of occupied entries.

Function
REQ-016 The buffer SHALL be a circular FIFO of DEPTH entries {sel, dat}, with head and tail pointers wrapping modulo DEPTH.
REQ-017 wb_ready SHALL equal (count < DEPTH); a push occurs when wb_valid && wb_ready.
REQ-018 A push with wb_sel == 0 SHALL be accepted (handshake completes) but SHALL NOT be enqueued.
REQ-019 WEN SHALL equal (count != 0) && !rf_hold; wsel/wdat SHALL present the head entry, and SHALL be 0 when count == 0.
REQ-020 A pop SHALL occur on each rising edge where WEN is high, advancing head by one.
REQ-021 Drain latency: an entry pushed into an empty buffer at edge N SHALL appear on WEN/wsel/wdat in the cycle after edge N and pop at edge N+1 if rf_hold is low.
REQ-022 Simultaneous push and pop SHALL leave count unchanged; wb_ready is not raised by a same-cycle pop when full.
REQ-023 Write order to the register file SHALL equal push order; duplicate destinations SHALL each be written in order.
REQ-024 rdatN SHALL be 0 when rselN == 0.
REQ-025 Otherwise rdatN SHALL be the dat of the youngest occupied entry whose sel == rselN, including the head entry currently on WEN.
REQ-026 With no matching entry, rdatN SHALL equal rf_rdatN.
REQ-027 A request being pushed in the same cycle SHALL NOT be forwarded; it is visible to rdatN from the next cycle.
REQ-028 rf_hold SHALL stall draining indefinitely without losing or reordering entries; pushes continue until full.
REQ-029 The block SHALL contain no combinational path from wb_valid/wb_sel/wb_dat to any output.

Reset
REQ-030 While nRST is low, count, head and tail SHALL be 0, and all entries SHALL be cleared to 0.
REQ-031 While nRST is low, WEN, wsel and wdat SHALL be 0, and wb_ready SHALL be 1.
REQ-032 Reset asserted mid-operation SHALL discard all pending entries without issuing writes.
REQ-033 After reset, rdatN SHALL pass rf_rdatN, or 0 for register 0.

Verification
REQ-034 Push {5, 0xDEADBEEF} into empty buffer, rf_hold=0 -> next cycle WEN=1, wsel=5, wdat=0xDEADBEEF; count returns to 0 after one more edge.
REQ-035 rf_hold=1, push {1,0x11},{2,0x22},{3,0x33},{4,0x44} -> count=4, wb_ready=0, WEN=0; fifth push stalls; release hold -> writes 1,2,3,4 on consecutive cycles.
REQ-036 Buffer holds {7,0xA},{7,0xB}, rsel1=7, rf_rdat1=0x0 -> rdat1=0xB; rsel2=8, rf_rdat2=0x55 -> rdat2=0x55.
REQ-037 Push {0, 0xFFFFFFFF} -> wb_ready=1 handshake, count stays 0, no WEN; rsel1=0 -> rdat1=0.
REQ-038 Full buffer with rf_hold=0 and wb_valid=1 continuously -> one write per cycle; pointers wrap past DEPTH-1 with no loss or duplication over 3*DEPTH requests.
REQ-039 Three entries pending, nRST pulsed low between edges -> count=0, WEN=0 immediately; no stale writes after release.
